barrel_shifter_pipe: RTL and testbench

//  Parametrised, pipelined barrel shifter; next generation of the 16-bit combinational left shifter.

---
 rtl/barrel_shifter_pipe.sv | 183 ++++++++++++++++++
 tb/tb_barrel_shifter_pipe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROL) with valid/ready handshake, one shift stage per amount bit.
// Optional macro SHIFTER_CARRY_OUT_EN adds a registered out_carry aligned with out_data.
module barrel_shifter_pipe #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef SHIFTER_CARRY_OUT_EN
    ,
    output logic             out_carry
`endif
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    logic           adv;
    logic           ovf;
    logic [SHW-1:0] lo;

    logic [WIDTH-1:0] sat_data;
    logic [SHW-1:0]   sat_amt;

    logic [WIDTH-1:0] st_data [SHW];
    logic [SHW-1:0]   st_valid;
    logic [1:0]       st_mode [SHW-1];
    logic [SHW-1:0]   st_amt  [SHW-1];

    logic [WIDTH-1:0] src_data [SHW];
    logic [1:0]       src_mode [SHW];
    logic [SHW-1:0]   src_amt  [SHW];
    logic [SHW-1:0]   src_valid;
    logic [WIDTH-1:0] nx_data  [SHW];

`ifdef SHIFTER_CARRY_OUT_EN
    logic           sat_carry;
    logic [SHW-1:0] st_carry;
    logic [SHW-1:0] src_carry;
    logic [SHW-1:0] nx_carry;
`endif

    assign out_valid = st_valid[SHW-1];
    assign out_data  = st_data[SHW-1];
    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;

    assign lo = in_amt[SHW-1:0];

    generate
        if (AMT_W > SHW) begin : g_ovf
            assign ovf = |in_amt[AMT_W-1:SHW];
        end else begin : g_no_ovf
            assign ovf = 1'b0;
        end
    endgenerate

    // Oversized amounts saturate here, so later stages only ever see a plain in-range shift.
    always_comb begin
        sat_data = in_data;
        sat_amt  = lo;
        if (ovf && (in_mode != MODE_ROL)) begin
            sat_amt  = '0;
            sat_data = (in_mode == MODE_ASR) ? {WIDTH{in_data[WIDTH-1]}} : '0;
        end
    end

`ifdef SHIFTER_CARRY_OUT_EN
    // Shifting by exactly WIDTH still pushes one real bit out; anything larger pushes out zeros.
    always_comb begin
        sat_carry = 1'b0;
        if (ovf) begin
            case (in_mode)
                MODE_LSL: sat_carry = (in_amt == AMT_W'(WIDTH)) & in_data[0];
                MODE_LSR: sat_carry = (in_amt == AMT_W'(WIDTH)) & in_data[WIDTH-1];
                MODE_ASR: sat_carry = in_data[WIDTH-1];
                default:  sat_carry = 1'b0;
            endcase
        end
    end
`endif

    generate
        for (genvar k = 0; k < SHW; k++) begin : g_stage
            localparam int SH = 1 << k;

            logic [WIDTH-1:0] d;
            logic [WIDTH-1:0] rol;
            logic [WIDTH-1:0] shifted;

            if (k == 0) begin : g_src_in
                assign src_data[0]  = sat_data;
                assign src_mode[0]  = in_mode;
                assign src_amt[0]   = sat_amt;
                assign src_valid[0] = in_valid;
`ifdef SHIFTER_CARRY_OUT_EN
                assign src_carry[0] = sat_carry;
`endif
            end else begin : g_src_prev
                assign src_data[k]  = st_data[k-1];
                assign src_mode[k]  = st_mode[k-1];
                assign src_amt[k]   = st_amt[k-1];
                assign src_valid[k] = st_valid[k-1];
`ifdef SHIFTER_CARRY_OUT_EN
                assign src_carry[k] = st_carry[k-1];
`endif
            end

            assign d   = src_data[k];
            assign rol = (d << SH) | (d >> (WIDTH - SH));

            always_comb begin
                case (src_mode[k])
                    MODE_LSL: shifted = d << SH;
                    MODE_LSR: shifted = d >> SH;
                    MODE_ASR: shifted = $signed(d) >>> SH;
                    default:  shifted = rol;
                endcase
            end

            assign nx_data[k] = src_amt[k][k] ? shifted : d;

`ifdef SHIFTER_CARRY_OUT_EN
            // The last stage that actually shifts owns the carry; idle stages pass it through.
            logic c_shift;
            always_comb begin
                case (src_mode[k])
                    MODE_LSL: c_shift = d[WIDTH-SH];
                    MODE_LSR: c_shift = d[SH-1];
                    MODE_ASR: c_shift = d[SH-1];
                    default:  c_shift = rol[0];
                endcase
            end
            assign nx_carry[k] = src_amt[k][k] ? c_shift : src_carry[k];
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            st_valid <= '0;
            for (int k = 0; k < SHW; k++) begin
                st_data[k] <= '0;
            end
            for (int k = 0; k < SHW - 1; k++) begin
                st_mode[k] <= MODE_LSL;
                st_amt[k]  <= '0;
            end
`ifdef SHIFTER_CARRY_OUT_EN
            st_carry <= '0;
`endif
        end else if (adv) begin
            st_valid <= src_valid;
            for (int k = 0; k < SHW; k++) begin
                st_data[k] <= nx_data[k];
            end
            for (int k = 0; k < SHW - 1; k++) begin
                st_mode[k] <= src_mode[k];
                st_amt[k]  <= src_amt[k];
            end
`ifdef SHIFTER_CARRY_OUT_EN
            st_carry <= nx_carry;
`endif
        end
    end

`ifdef SHIFTER_CARRY_OUT_EN
    assign out_carry = st_carry[SHW-1];
`endif

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe (WIDTH=16, AMT_W=8): vector table plus latency, stall and reset sequences.
module tb_barrel_shifter_pipe;

    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROL = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [7:0]  in_amt = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
`ifdef SHIFTER_CARRY_OUT_EN
    logic        out_carry;
`endif

    barrel_shifter_pipe #(.WIDTH(16), .AMT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef SHIFTER_CARRY_OUT_EN
        ,
        .out_carry (out_carry)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] data;
        logic [7:0]  amt;
        logic [15:0] res;
        logic        c;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic        c;
    } exp_t;

    vec_t  vecs[$];
    exp_t  exp_q[$];
    exp_t  mon_x;
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    last_acc = 0;
    logic        hold_chk = 1'b0;
    logic [15:0] held_data = '0;
    logic        held_c = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Output monitor: in-order scoreboard plus stability while stalled.
    always @(negedge clk) begin
        if (rst) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(held_data));
`ifdef SHIFTER_CARRY_OUT_EN
                chk("hold_carry", 32'(out_carry), 32'(held_c));
`endif
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got data %0h, want no beat", out_data);
                end else begin
                    mon_x = exp_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(mon_x.data));
`ifdef SHIFTER_CARRY_OUT_EN
                    chk("out_carry", 32'(out_carry), 32'(mon_x.c));
`endif
                end
            end
            hold_chk  = out_valid && !out_ready;
            held_data = out_data;
`ifdef SHIFTER_CARRY_OUT_EN
            held_c    = out_carry;
`endif
        end
    end

    // Called just after a posedge; returns just after the accepting posedge with in_valid still high.
    task automatic send(input logic [1:0] m, input logic [15:0] d, input logic [7:0] a,
                        input logic [15:0] e, input logic c);
        int   n;
        exp_t x;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        in_amt   = a;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                total++;
                bad++;
                $display("FAIL send_timeout: in_ready low for %0d cycles, want 1", n);
                break;
            end
            @(posedge clk);
            #1;
        end
        last_acc = cyc;
        x.data = e;
        x.c    = c;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int lat, input int acc);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc - acc;
                break;
            end
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int a1;
        int a2;

        vecs.push_back('{ASR, 16'h8000, 8'd3,   16'hF000, 1'b0});
        vecs.push_back('{ASR, 16'h8000, 8'd200, 16'hFFFF, 1'b1});
        vecs.push_back('{LSR, 16'h8000, 8'd20,  16'h0000, 1'b0});
        vecs.push_back('{LSL, 16'hFFFF, 8'd16,  16'h0000, 1'b1});
        vecs.push_back('{ROL, 16'h8001, 8'd1,   16'h0003, 1'b1});
        vecs.push_back('{ROL, 16'h1234, 8'd20,  16'h2341, 1'b1});
        vecs.push_back('{LSL, 16'h8000, 8'd1,   16'h0000, 1'b1});
        vecs.push_back('{LSR, 16'h00F0, 8'd4,   16'h000F, 1'b0});
        vecs.push_back('{LSR, 16'h8001, 8'd16,  16'h0000, 1'b1});
        vecs.push_back('{ASR, 16'h7FFF, 8'd15,  16'h0000, 1'b1});
        vecs.push_back('{ASR, 16'h7000, 8'd255, 16'h0000, 1'b0});
        vecs.push_back('{LSL, 16'hA5A5, 8'd0,   16'hA5A5, 1'b0});
        vecs.push_back('{ASR, 16'h8001, 8'd0,   16'h8001, 1'b0});
        vecs.push_back('{ROL, 16'h1234, 8'd16,  16'h1234, 1'b0});
        vecs.push_back('{ROL, 16'h8000, 8'd15,  16'h4000, 1'b0});
        vecs.push_back('{LSL, 16'h0003, 8'd15,  16'h8000, 1'b1});
        vecs.push_back('{LSR, 16'hFFFF, 8'd7,   16'h01FF, 1'b1});
        vecs.push_back('{ASR, 16'h9000, 8'd4,   16'hF900, 1'b0});
        vecs.push_back('{LSL, 16'h1234, 8'd4,   16'h2340, 1'b1});

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
`ifdef SHIFTER_CARRY_OUT_EN
        chk("rst_out_carry", 32'(out_carry), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Latency and back-to-back throughput
        send(LSL, 16'h0001, 8'd1, 16'h0002, 1'b0);
        a1 = last_acc;
        send(LSL, 16'h0001, 8'd2, 16'h0004, 1'b0);
        a2 = last_acc;
        in_valid = 1'b0;
        wait_valid(lat, a1);
        chk("latency_first", 32'(lat), 32'd4);
        @(negedge clk);
        chk("second_valid", 32'(out_valid), 32'd1);
        chk("latency_second", 32'(cyc - a2), 32'd4);
        drain("drain_latency");

        // Vector table streamed back to back
        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].mode, vecs[i].data, vecs[i].amt, vecs[i].res, vecs[i].c);
        end
        in_valid = 1'b0;
        drain("drain_table");

        // Six beats with a five-cycle output stall in the middle
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(LSL, 16'(i + 1), 8'(i), 16'((i + 1) << i), 1'b0);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                    chk("stall_out_valid", 32'(out_valid), 32'd1);
                    if (i < 4) begin
                        @(posedge clk);
                        #1;
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("drain_stall");

        // Reset with three beats in flight
        send(LSL, 16'h0001, 8'd3, 16'h0008, 1'b0);
        send(LSL, 16'h0001, 8'd5, 16'h0020, 1'b0);
        send(LSL, 16'h0001, 8'd7, 16'h0080, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("flush_no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(ASR, 16'h8000, 8'd1, 16'hC000, 1'b0);
        a1 = last_acc;
        in_valid = 1'b0;
        wait_valid(lat, a1);
        chk("latency_after_rst", 32'(lat), 32'd4);
        drain("drain_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
